// File: rtl/ltl_mon_pkg.sv
// Shared constants for the LTL monitor report path.
// Provides default widths for the report collector and the helper that sizes
// FIFO occupancy counters (enough bits to hold the value DEPTH itself).
package ltl_mon_pkg;

  localparam int unsigned NUM_REPORTS_DEF = 4;
  localparam int unsigned IDX_W_DEF       = 16;
  localparam int unsigned DROP_W_DEF      = 8;
  localparam int unsigned DEPTH_DEF       = 8;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   flush_i         synchronous pointer flush
//   push_i, din_i   write request and data; ignored when full unless popping
//   pop_i           consume head; ignored when empty
//   dout_o          head entry, zero while empty
//   full_o, empty_o, count_o  occupancy status
module ltl_report_fifo
  import ltl_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          din_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [occ_w(DEPTH)-1:0]   count_o
);

  localparam int unsigned CW = occ_w(DEPTH);
  localparam int unsigned AW = CW - 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0]    wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i && do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ltl_report_collector.sv
// Collects report-state outputs of an LTL monitor automaton.
// Each symbol cycle with a report is tagged with its 0-based symbol index and
// buffered in an FWFT FIFO that drains over a valid/ready handshake. Sticky
// overflow, saturating drop count and any-hit status feed the CSR block.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   run                   automaton consumed a symbol this cycle
//   clear                 synchronous soft clear of FIFO, index and status
//   report_in             automaton report outputs, cluster order
//   out_valid/out_ready   head handshake; out_reports/out_index head record
//   count                 FIFO occupancy
//   overflow, drop_count, any_hit  status
module ltl_report_collector
  import ltl_mon_pkg::*;
#(
  parameter int unsigned NUM_REPORTS = NUM_REPORTS_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned DROP_W      = DROP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     clear,
  input  logic [NUM_REPORTS-1:0]   report_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_REPORTS-1:0]   out_reports,
  output logic [IDX_W-1:0]         out_index,
  output logic [occ_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     any_hit
);

  localparam int unsigned REC_W = NUM_REPORTS + IDX_W;

  // run_q marks the cycle in which report_in reflects the previous symbol.
  logic              run_q;
  logic [IDX_W-1:0]  sym_idx_q, sym_idx_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              any_hit_q, any_hit_d;

  logic              hit, pop, drop, full, empty;
  logic [REC_W-1:0]  head;

  assign hit  = run_q & (|report_in);
  assign pop  = out_valid & out_ready;
  assign drop = hit & full & ~pop;

  always_comb begin
    sym_idx_d  = sym_idx_q + IDX_W'(run_q);
    any_hit_d  = any_hit_q | hit;
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      run_q      <= 1'b0;
      sym_idx_q  <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      any_hit_q  <= 1'b0;
    end else begin
      run_q      <= run;
      sym_idx_q  <= sym_idx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      any_hit_q  <= any_hit_d;
    end
  end

  ltl_report_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (clear),
    .push_i  (hit),
    .din_i   ({report_in, sym_idx_q}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign out_valid                = ~empty;
  assign {out_reports, out_index} = head;
  assign overflow                 = overflow_q;
  assign drop_count               = drop_q;
  assign any_hit                  = any_hit_q;

endmodule

// File: tb/tb_ltl_report_collector.sv
module tb_ltl_report_collector;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, run, clear, out_ready;
  logic [3:0]  report_in;

  logic        out_valid, out_valid2;
  logic [3:0]  out_reports, out_reports2;
  logic [15:0] out_index, out_index2;
  logic [3:0]  count, count2;
  logic        overflow, overflow2, any_hit, any_hit2;
  logic [7:0]  drop_count;
  logic [1:0]  drop_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ltl_report_collector #(
    .NUM_REPORTS (4), .IDX_W (16), .DEPTH (DEPTH), .DROP_W (8)
  ) u_dut (
    .clk (clk), .reset (reset), .run (run), .clear (clear),
    .report_in (report_in), .out_valid (out_valid), .out_ready (out_ready),
    .out_reports (out_reports), .out_index (out_index), .count (count),
    .overflow (overflow), .drop_count (drop_count), .any_hit (any_hit)
  );

  ltl_report_collector #(
    .NUM_REPORTS (4), .IDX_W (16), .DEPTH (DEPTH), .DROP_W (2)
  ) u_dut_sat (
    .clk (clk), .reset (reset), .run (run), .clear (clear),
    .report_in (report_in), .out_valid (out_valid2), .out_ready (out_ready),
    .out_reports (out_reports2), .out_index (out_index2), .count (count2),
    .overflow (overflow2), .drop_count (drop_count2), .any_hit (any_hit2)
  );

  typedef struct {
    logic        run, clr;
    logic [3:0]  rep;
    logic        rdy;
    logic        ev;
    logic [3:0]  erep;
    logic [15:0] eidx;
    int          ecnt;
    logic        eovf;
    int          edrop;
    logic        eany;
  } vec_t;

  vec_t tv[$];

  // Reference model state: records are {reports, index}.
  logic [19:0] mq[$];
  logic        m_run;
  logic [15:0] m_idx;
  logic        m_ovf, m_any;
  int          m_drops;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string ctx, input logic ev, input logic [3:0] erep,
                         input logic [15:0] eidx, input int ecnt, input logic eovf,
                         input int edrop, input logic eany);
    int d2;
    d2 = (edrop > 3) ? 3 : edrop;
    chk({ctx, " out_valid"},   64'(out_valid),   64'(ev));
    chk({ctx, " out_reports"}, 64'(out_reports), 64'(erep));
    chk({ctx, " out_index"},   64'(out_index),   64'(eidx));
    chk({ctx, " count"},       64'(count),       64'(ecnt));
    chk({ctx, " overflow"},    64'(overflow),    64'(eovf));
    chk({ctx, " drop_count"},  64'(drop_count),  64'((edrop > 255) ? 255 : edrop));
    chk({ctx, " drop_sat"},    64'(drop_count2), 64'(d2));
    chk({ctx, " any_hit"},     64'(any_hit),     64'(eany));
  endtask

  task automatic step(input logic r, input logic c, input logic [3:0] rp, input logic rdy);
    run = r; clear = c; report_in = rp; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic c, input logic [3:0] rp,
                              input logic rdy, input logic ev, input logic [3:0] erep,
                              input logic [15:0] eidx, input int ecnt, input logic eany);
    vec_t v;
    v.run = r; v.clr = c; v.rep = rp; v.rdy = rdy;
    v.ev = ev; v.erep = erep; v.eidx = eidx; v.ecnt = ecnt;
    v.eovf = 1'b0; v.edrop = 0; v.eany = eany;
    return v;
  endfunction

  task automatic model_step(input logic rst, input logic r, input logic c,
                            input logic [3:0] rp, input logic rdy);
    logic was_full, pop, hit;
    if (rst || c) begin
      mq.delete();
      m_run = 0; m_idx = 0; m_ovf = 0; m_any = 0; m_drops = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      pop      = (mq.size() > 0) && rdy;
      hit      = m_run && (rp != 4'b0);
      if (pop) void'(mq.pop_front());
      if (hit) begin
        if (!was_full || pop) mq.push_back({rp, m_idx});
        else begin
          m_ovf = 1;
          m_drops++;
        end
      end
      if (m_run) m_idx = m_idx + 16'd1;
      m_any = m_any | hit;
      m_run = r;
    end
  endtask

  task automatic model_check(input string ctx);
    logic [19:0] h;
    h = (mq.size() > 0) ? mq[0] : 20'h0;
    chk_all(ctx, mq.size() > 0, h[19:16], h[15:0], mq.size(), m_ovf, m_drops, m_any);
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; clear = 1'b0; report_in = 4'hF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 4'h0, 16'h0, 0, 0, 0, 0);
    reset = 1'b0;

    // Idle symbols, then a hit exposing the index after five symbols.
    for (int i = 0; i < 5; i++) tv.push_back(mk(1, 0, 4'h0, 0, 0, 4'h0, 16'd0, 0, 0));
    tv.push_back(mk(0, 0, 4'h0, 0, 0, 4'h0, 16'd0, 0, 0));
    tv.push_back(mk(1, 0, 4'h0, 0, 0, 4'h0, 16'd0, 0, 0));
    tv.push_back(mk(0, 0, 4'h8, 0, 1, 4'h8, 16'd5, 1, 1));
    tv.push_back(mk(0, 1, 4'h0, 0, 0, 4'h0, 16'd0, 0, 0));
    // Four symbols, report for the third one, sink ready throughout.
    tv.push_back(mk(1, 0, 4'h0, 1, 0, 4'h0, 16'd0, 0, 0));
    tv.push_back(mk(1, 0, 4'h0, 1, 0, 4'h0, 16'd0, 0, 0));
    tv.push_back(mk(1, 0, 4'h0, 1, 0, 4'h0, 16'd0, 0, 0));
    tv.push_back(mk(1, 0, 4'h2, 1, 1, 4'h2, 16'd2, 1, 1));
    tv.push_back(mk(0, 0, 4'h0, 1, 0, 4'h0, 16'd0, 0, 1));
    // Reports without a preceding run are ignored.
    tv.push_back(mk(0, 0, 4'hF, 0, 0, 4'h0, 16'd0, 0, 1));
    tv.push_back(mk(0, 0, 4'hF, 1, 0, 4'h0, 16'd0, 0, 1));

    foreach (tv[i]) begin
      step(tv[i].run, tv[i].clr, tv[i].rep, tv[i].rdy);
      chk_all($sformatf("vec%0d", i), tv[i].ev, tv[i].erep, tv[i].eidx,
              tv[i].ecnt, tv[i].eovf, tv[i].edrop, tv[i].eany);
    end

    // Overflow: ten hits into eight entries, then drain in order.
    step(0, 1, 4'h0, 0);
    for (int i = 0; i <= 10; i++) begin
      step(i < 10, 0, (i >= 1) ? 4'h5 : 4'h0, 0);
      if (i == 8) chk("ovf_before_first_drop", 64'(overflow), 64'd0);
      if (i == 9) chk("ovf_after_first_drop", 64'(overflow), 64'd1);
      if (i >= 1) chk($sformatf("ovf_head_stable%0d", i), 64'(out_index), 64'd0);
    end
    chk_all("ovf_full", 1, 4'h5, 16'd0, 8, 1, 2, 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_idx%0d", k), 64'(out_index), 64'(k));
      chk($sformatf("drain_cnt%0d", k), 64'(count), 64'(8 - k));
      step(0, 0, 4'h0, 1);
    end
    chk_all("drained", 0, 4'h0, 16'd0, 0, 1, 2, 1);

    // Full FIFO: hit coincides with a pop, so nothing is dropped.
    step(0, 1, 4'h0, 0);
    for (int i = 0; i <= 9; i++) begin
      if (i == 9) chk("fp_full_before", 64'(count), 64'd8);
      step(i < 9, 0, (i >= 1) ? 4'h3 : 4'h0, i == 9);
    end
    chk_all("fp_after", 1, 4'h3, 16'd1, 8, 0, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("fp_drain_idx%0d", k), 64'(out_index), 64'(k));
      step(0, 0, 4'h0, 1);
    end
    chk("fp_empty", 64'(out_valid), 64'd0);

    // Saturation: thirteen hits, five drops; 2-bit counter stops at 3.
    step(0, 1, 4'h0, 0);
    for (int i = 0; i <= 13; i++) step(i < 13, 0, (i >= 1) ? 4'h1 : 4'h0, 0);
    chk_all("sat", 1, 4'h1, 16'd0, 8, 1, 5, 1);

    // Leave three queued, then clear coincident with a hit and a pop.
    for (int k = 0; k < 5; k++) step(k == 4, 0, 4'h0, 1);
    chk("clr_pre_count", 64'(count), 64'd3);
    step(0, 1, 4'h4, 1);
    chk_all("clr_hit", 0, 4'h0, 16'd0, 0, 0, 0, 0);
    step(1, 0, 4'h0, 0);
    step(0, 0, 4'h2, 0);
    chk_all("clr_next", 1, 4'h2, 16'd0, 1, 0, 0, 1);

    // Randomized traffic against the queue model.
    reset = 1'b1;
    step(0, 0, 4'h0, 0);
    model_step(1, 0, 0, 4'h0, 0);
    reset = 1'b0;
    model_check("rnd_reset");
    begin
      int rdy_pct;
      logic r, c, rst, rdy;
      logic [3:0] rp;
      rdy_pct = 50;
      for (int n = 0; n < 3000; n++) begin
        if (n % 200 == 0) begin
          case ($urandom_range(0, 2))
            0: rdy_pct = 10;
            1: rdy_pct = 50;
            default: rdy_pct = 90;
          endcase
        end
        r   = ($urandom_range(0, 99) < 60);
        c   = ($urandom_range(0, 299) == 0);
        rst = ($urandom_range(0, 499) == 0);
        rp  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        model_step(rst, r, c, rp, rdy);
        reset = rst;
        step(r, c, rp, rdy);
        reset = 1'b0;
        model_check($sformatf("rnd%0d", n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ltl_report_collector.md
Name: ltl_report_collector

Overview:
- Downstream stage of a generated LTL monitor automaton. Consumes the automaton's report-state outputs, for example `w_out_4`, `w_out_6`, `w_out_9` and `w_out_11` of a 4-report cluster.
- Tags each reporting symbol cycle with its symbol index and buffers the record in a first-word-fall-through (FWFT) FIFO.
- Presents records to the trace/debug sink over a valid/ready handshake.
- Keeps sticky overflow, drop-count and any-hit status for the monitor CSR block.

Parameters:
- NUM_REPORTS, 4: width of the report vector; one bit per report STE.
- IDX_W, 16: width of the symbol index counter.
- DEPTH, 8: FIFO entries; must be a power of 2 and at least 2.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  automaton consumed a symbol this cycle; same signal that drives the STE `run` inputs.
- clear  in  1  synchronous soft clear of FIFO, index and status.
- report_in  in  NUM_REPORTS  automaton report outputs, concatenated in cluster order.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  sink accepts the head.
- out_reports  out  NUM_REPORTS  report vector of the head record.
- out_index  out  IDX_W  symbol index of the head record.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- overflow  out  1  sticky: at least one record was dropped.
- drop_count  out  DROP_W  number of dropped records; saturates at all-ones.
- any_hit  out  1  sticky: at least one report has been seen.

Behaviour:
- Reset values: out_valid=0, count=0, overflow=0, drop_count=0, any_hit=0, sym_idx=0, run_d=0. out_reports and out_index are 0 while empty.
- Alignment:
  - STE outputs for symbol k become valid the cycle after run is high with k.
  - The collector registers run into run_d and samples report_in only when run_d=1.
- Index counter:
  - sym_idx increments on every cycle with run_d=1, after capture.
  - The captured index equals the 0-based count of symbols consumed since reset/clear.
  - Wraps modulo 2^IDX_W with no flag.
- Capture: hit = run_d & |report_in. On hit, record {report_in, sym_idx} and set any_hit.
- Push rules:
  - not full: push.
  - full and pop in the same cycle: push accepted and count stays DEPTH.
  - full and no pop: record dropped, overflow set, drop_count incremented unless already all-ones.
- Pop: out_valid & out_ready.
  - FWFT: head visible combinationally from storage.
  - A record captured at edge N is visible on out_* after edge N (latency 1 from sampling, 2 from run).
  - Push into an empty FIFO with out_ready=1 is not bypassed; the record appears the next cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- out_* must stay stable while out_valid=1 and out_ready=0.
- clear (also reset):
  - Flushes FIFO pointers.
  - Zeroes sym_idx, run_d, overflow, drop_count and any_hit.
  - Overrides any capture or pop in the same cycle.
  - Asserting either mid-stream discards all queued records; no partial record survives.
- run=0 holds sym_idx; report_in is ignored regardless of its value.
- Status outputs are registered; overflow and drop_count update the cycle after the dropped hit.

Decomposition:
- Shared package ltl_mon_pkg: default constants NUM_REPORTS_DEF, IDX_W_DEF, DROP_W_DEF.
- Also in ltl_mon_pkg: a localparam function for the occupancy width.
- Sub-module ltl_report_fifo:
  - Synchronous FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports push/pop/flush/full/empty/count, no overflow logic.
- The collector owns alignment, indexing, drop accounting and status.

Test Plan:
- Reset, then run=1 for 5 cycles with report_in=0 -> out_valid stays 0, any_hit=0, internal sym_idx=5.
- Pulse run=1 for 4 symbols; report_in=4'b0010 only in the cycle after the 3rd run, with out_ready=1 -> one record with out_reports=4'b0010, out_index=2, any_hit=1.
- Hold out_ready=0 and generate 10 consecutive hits with DEPTH=8 -> count=8, overflow=1, drop_count=2. Then drain with out_ready=1 -> indices 0..7 in order, then out_valid=0.
- FIFO full and hit coincide with a pop -> no drop (drop_count unchanged), count stays 8, the new record appears last.
- Set DROP_W=2 and generate 5 drops -> drop_count saturates at 3.
- Assert clear in the same cycle as a hit with 3 records queued -> count=0, out_valid=0, overflow=0, any_hit=0. The next hit is reported with index 0.
